// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Widths, the hard-wired zero register and requester ids.
package regfile_wb_arbiter_pkg;

  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback holding slot with valid/ready handshake.
// Writes to the zero register are accepted and dropped.
module wb_hold_slot
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          valid_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  input  logic          grant_i,
  output logic          ready_o,
  output logic          full_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o
);

  logic          full_q, full_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          xfer;

  always_comb begin
    full_d  = full_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ready_o = !full_q || grant_i;
    xfer    = valid_i && ready_o;
    if (xfer) begin
      full_d = (addr_i != AW'(REG_ZERO));
      if (full_d) begin
        addr_d = addr_i;
        data_d = data_i;
      end
    end else if (grant_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port between
// the main pipeline (A) and the mult/div unit (B).
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  output logic                ctrl_writeEnable,
  output logic [ADDR_W-1:0]   ctrl_writeReg,
  output logic [NUM_REGS-1:0] wr_onehot,
  output logic [DATA_W-1:0]   wr_data,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    commit_count
);

  logic              a_full, b_full;
  logic [ADDR_W-1:0] a_addr_q, b_addr_q;
  logic [DATA_W-1:0] a_data_q, b_data_q;
  logic              grant_a, grant_b;
  req_e              rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  wb_hold_slot #(.AW(ADDR_W), .DW(DATA_W)) u_slot_a (
    .clock   (clock),
    .reset   (reset),
    .valid_i (a_valid),
    .addr_i  (a_addr),
    .data_i  (a_data),
    .grant_i (grant_a),
    .ready_o (a_ready),
    .full_o  (a_full),
    .addr_o  (a_addr_q),
    .data_o  (a_data_q)
  );

  wb_hold_slot #(.AW(ADDR_W), .DW(DATA_W)) u_slot_b (
    .clock   (clock),
    .reset   (reset),
    .valid_i (b_valid),
    .addr_i  (b_addr),
    .data_i  (b_data),
    .grant_i (grant_b),
    .ready_o (b_ready),
    .full_o  (b_full),
    .addr_o  (b_addr_q),
    .data_o  (b_data_q)
  );

  // Under contention the requester that did not win last time goes.
  assign grant_a = a_full && (!b_full || rr_last_q == REQ_B);
  assign grant_b = b_full && (!a_full || rr_last_q == REQ_A);

  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    wr_data          = '0;
    rr_last_d        = rr_last_q;
    unique case (1'b1)
      grant_a: begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = a_addr_q;
        wr_data          = a_data_q;
        rr_last_d        = REQ_A;
      end
      grant_b: begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = b_addr_q;
        wr_data          = b_data_q;
        rr_last_d        = REQ_B;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_onehot = '0;
    pending   = '0;
    if (ctrl_writeEnable)
      wr_onehot = NUM_REGS'(1) << ctrl_writeReg;
    if (a_full)
      pending = pending | (NUM_REGS'(1) << a_addr_q);
    if (b_full)
      pending = pending | (NUM_REGS'(1) << b_addr_q);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ctrl_writeEnable && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_last_q <= REQ_B;
      cnt_q     <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign commit_count = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter against
// a behavioural slot/arbitration model.
module tb_regfile_wb_arbiter;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [4:0]    a_addr, b_addr;
  logic [31:0]   a_data, b_data;
  logic          ctrl_writeEnable;
  logic [4:0]    ctrl_writeReg;
  logic [31:0]   wr_onehot, wr_data, pending;
  logic [CW-1:0] commit_count;

  always #5 clock = ~clock;

  regfile_wb_arbiter #(
    .DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .CNT_W(CW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .a_valid          (a_valid),
    .a_ready          (a_ready),
    .a_addr           (a_addr),
    .a_data           (a_data),
    .b_valid          (b_valid),
    .b_ready          (b_ready),
    .b_addr           (b_addr),
    .b_data           (b_data),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .wr_onehot        (wr_onehot),
    .wr_data          (wr_data),
    .pending          (pending),
    .commit_count     (commit_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  bit          mf[2];
  logic [4:0]  ma[2];
  logic [31:0] md[2];
  int          mlast;
  int          mcnt;
  bit          held[2];
  logic [31:0] mreg[32];
  logic [31:0] dreg[32];
  wr_t         qa[$];
  wr_t         qb[$];
  logic [4:0]  log_q[$];
  int          rate;
  int          p7;

  task automatic model_clear();
    for (int x = 0; x < 2; x++) begin
      mf[x] = 0; ma[x] = '0; md[x] = '0; held[x] = 0;
    end
    mlast = 1;
    mcnt  = 0;
    qa.delete();
    qb.delete();
  endtask

  task automatic reset_all();
    reset   = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic step();
    int          g;
    bit          rdy[2];
    bit          v[2];
    wr_t         h[2];
    logic [31:0] pend, eo, ed;
    logic [4:0]  ea;
    @(negedge clock);
    g = -1;
    if (mf[0] && mf[1]) g = (mlast == 0) ? 1 : 0;
    else if (mf[0]) g = 0;
    else if (mf[1]) g = 1;
    pend = '0;
    for (int x = 0; x < 2; x++) begin
      rdy[x] = !mf[x] || (g == x);
      if (mf[x]) pend[ma[x]] = 1'b1;
    end
    ea = '0; ed = '0; eo = '0;
    if (g >= 0) begin
      ea = ma[g]; ed = md[g]; eo[ea] = 1'b1;
    end
    check("a_ready", 64'(a_ready), 64'(rdy[0]));
    check("b_ready", 64'(b_ready), 64'(rdy[1]));
    check("we", 64'(ctrl_writeEnable), 64'(g >= 0));
    check("wreg", 64'(ctrl_writeReg), 64'(ea));
    check("wdata", 64'(wr_data), 64'(ed));
    check("onehot", 64'(wr_onehot), 64'(eo));
    check("pending", 64'(pending), 64'(pend));
    check("count", 64'(commit_count), 64'(mcnt));
    if (ctrl_writeEnable) begin
      dreg[ctrl_writeReg] = wr_data;
      log_q.push_back(ctrl_writeReg);
    end
    if (pending[7]) p7++;
    h[0] = '{a: '0, d: '0};
    h[1] = '{a: '0, d: '0};
    if (qa.size() > 0) h[0] = qa[0];
    if (qb.size() > 0) h[1] = qb[0];
    v[0] = held[0] ||
           (qa.size() > 0 && $urandom_range(99) < rate);
    v[1] = held[1] ||
           (qb.size() > 0 && $urandom_range(99) < rate);
    a_valid = v[0]; a_addr = h[0].a; a_data = h[0].d;
    b_valid = v[1]; b_addr = h[1].a; b_data = h[1].d;
    if (g >= 0) begin
      mreg[ma[g]] = md[g];
      mlast = g;
      if (mcnt < CMAX) mcnt++;
    end
    for (int x = 0; x < 2; x++) begin
      held[x] = v[x] && !rdy[x];
      if (v[x] && rdy[x]) begin
        if (x == 0) void'(qa.pop_front());
        else        void'(qb.pop_front());
        mf[x] = (h[x].a != 5'd0);
        if (mf[x]) begin
          ma[x] = h[x].a; md[x] = h[x].d;
        end
      end else if (g == x) begin
        mf[x] = 0;
      end
    end
  endtask

  function automatic wr_t mk(input int a, input logic [31:0] d);
    wr_t w;
    w.a = 5'(a);
    w.d = d;
    return w;
  endfunction

  int steps;
  int exp_order[6] = '{1, 17, 2, 18, 3, 19};

  initial begin
    for (int i = 0; i < 32; i++) begin
      mreg[i] = '0; dreg[i] = '0;
    end
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
    rate = 100;
    p7   = 0;
    reset_all();

    qa.push_back(mk(3, 32'hDEADBEEF));
    log_q.delete();
    repeat (4) step();
    check("t1_log_n", 64'(log_q.size()), 64'd1);
    check("t1_reg3", 64'(dreg[3]), 64'hDEADBEEF);
    check("t1_count", 64'(commit_count), 64'd1);

    qa.push_back(mk(0, 32'h12345678));
    log_q.delete();
    repeat (3) step();
    check("t3_log_n", 64'(log_q.size()), 64'd0);
    check("t3_count", 64'(commit_count), 64'd1);
    check("t3_pending", 64'(pending), 64'd0);

    reset_all();
    for (int i = 0; i < 3; i++) begin
      qa.push_back(mk(1 + i, 32'hA000 + i));
      qb.push_back(mk(17 + i, 32'hB000 + i));
    end
    log_q.delete();
    repeat (9) step();
    check("t2_log_n", 64'(log_q.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < log_q.size())
        check("t2_order", 64'(log_q[i]), 64'(exp_order[i]));

    reset_all();
    qa.push_back(mk(7, 32'h1));
    qb.push_back(mk(7, 32'h2));
    log_q.delete();
    p7 = 0;
    repeat (5) step();
    check("t4_log_n", 64'(log_q.size()), 64'd2);
    check("t4_p7_cycles", 64'(p7), 64'd2);
    check("t4_reg7", 64'(dreg[7]), 64'h2);

    for (int i = 0; i < 6; i++)
      qa.push_back(mk(5, $urandom));
    log_q.delete();
    repeat (8) step();
    check("t5_log_n", 64'(log_q.size()), 64'd6);

    rate = 60;
    for (int i = 0; i < 40; i++) begin
      qa.push_back(mk(($urandom_range(7) == 0) ? 0 :
                      $urandom_range(31, 1), $urandom));
      qb.push_back(mk(($urandom_range(7) == 0) ? 0 :
                      $urandom_range(31, 1), $urandom));
    end
    steps = 0;
    while ((qa.size() > 0 || qb.size() > 0 || mf[0] || mf[1])
           && steps < 1000) begin
      step();
      steps++;
    end
    check("t6_drained", 64'(steps < 1000), 64'd1);
    repeat (2) step();
    check("t6_count_sat", 64'(commit_count), 64'(CMAX));

    rate = 100;
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mk(10 + i, $urandom));
      qb.push_back(mk(20 + i, $urandom));
    end
    repeat (3) step();
    check("t7_both_full", 64'(mf[0] && mf[1]), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t7_async_we", 64'(ctrl_writeEnable), 64'd0);
    check("t7_async_reg", 64'(ctrl_writeReg), 64'd0);
    check("t7_async_oh", 64'(wr_onehot), 64'd0);
    check("t7_async_data", 64'(wr_data), 64'd0);
    check("t7_async_pend", 64'(pending), 64'd0);
    check("t7_async_cnt", 64'(commit_count), 64'd0);
    reset_all();
    qa.push_back(mk(9, 32'h99));
    qb.push_back(mk(10, 32'hAA));
    log_q.delete();
    repeat (4) step();
    check("t7_log_n", 64'(log_q.size()), 64'd2);
    if (log_q.size() > 0)
      check("t7_first_a", 64'(log_q[0]), 64'd9);

    for (int i = 1; i < 32; i++)
      check("regfile", 64'(dreg[i]), 64'(mreg[i]));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
